// File: rtl/mem_dump_unit.sv
// Post-halt memory dump engine: on a double-signature match in x30/x31 it freezes
// the core and streams DUMP_WORDS words from DUMP_BASE over a valid/ready port.
module mem_dump_unit #(
   parameter logic [31:0] DUMP_BASE  = 32'h0000_0000,
   parameter int unsigned DUMP_WORDS = 1024,
   parameter logic [31:0] HALT_SIG   = 32'hBEEF_BEEF
) (
   input  logic        clk,
   input  logic        nrst,
   input  logic [31:0] x30_i,
   input  logic [31:0] x31_i,
   output logic        mem_ren,
   output logic [31:0] mem_addr,
   input  logic [31:0] mem_rdata,
   output logic        halt,
   output logic        dump_valid,
   input  logic        dump_ready,
   output logic [31:0] dump_addr,
   output logic [31:0] dump_data,
   output logic        done
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_WAIT,
      S_SEND,
      S_DONE
   } state_t;

   localparam logic [29:0] LAST_IDX = 30'(DUMP_WORDS - 1);

   state_t      state_q, state_d;
   logic [29:0] idx_q, idx_d;
   logic [31:0] dump_addr_q, dump_addr_d;
   logic [31:0] dump_data_q, dump_data_d;

   logic        sig_match;
   logic        beat_accept;
   logic        last_word;
   logic [31:0] word_addr;

   // Both registers must carry the signature in the same cycle; one alone is ignored.
   assign sig_match   = (x30_i == HALT_SIG) && (x31_i == HALT_SIG);
   assign beat_accept = (state_q == S_SEND) && dump_ready;
   assign last_word   = (idx_q == LAST_IDX);
   assign word_addr   = DUMP_BASE + {idx_q, 2'b00};

   always_ff @(posedge clk) begin
      if (!nrst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (sig_match) begin
               state_d = S_READ;
            end
         end
         S_READ: state_d = S_WAIT;
         S_WAIT: state_d = S_SEND;
         S_SEND: begin
            if (dump_ready) begin
               state_d = last_word ? S_DONE : S_READ;
            end
         end
         S_DONE: state_d = S_DONE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      mem_ren    = (state_q == S_READ);
      mem_addr   = (state_q == S_READ) ? word_addr : 32'h0;
      dump_valid = (state_q == S_SEND);
      done       = (state_q == S_DONE);
      halt       = (state_q != S_IDLE);
      dump_addr  = dump_addr_q;
      dump_data  = dump_data_q;
   end

   always_ff @(posedge clk) begin
      if (!nrst) begin
         idx_q       <= '0;
         dump_addr_q <= '0;
         dump_data_q <= '0;
      end else begin
         idx_q       <= idx_d;
         dump_addr_q <= dump_addr_d;
         dump_data_q <= dump_data_d;
      end
   end

   // The read address is recomputed in WAIT; idx only moves on acceptance, so it matches READ.
   always_comb begin
      idx_d       = idx_q;
      dump_addr_d = dump_addr_q;
      dump_data_d = dump_data_q;
      if ((state_q == S_IDLE) && sig_match) begin
         idx_d = '0;
      end
      if (state_q == S_WAIT) begin
         dump_addr_d = word_addr;
         dump_data_d = mem_rdata;
      end
      if (beat_accept && !last_word) begin
         idx_d = idx_q + 30'd1;
      end
   end

endmodule

// File: doc/mem_dump_unit.md
MEM_DUMP_UNIT -- requirements
Module: mem_dump_unit

Interface
REQ-001 Parameter DUMP_BASE, default 32'h0000_0000, byte address of the first word dumped.
REQ-002 Parameter DUMP_WORDS, default 1024, number of 32-bit words dumped; legal range 1..2^30.
REQ-003 Parameter HALT_SIG, default 32'hBEEFBEEF, halt signature value.
REQ-004 The block SHALL have one clock, clk; reset is synchronous and active-low, port nrst.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 nrst  input  1  synchronous active-low reset.
REQ-007 x30_i  input  32  live value of register x30.
REQ-008 x31_i  input  32  live value of register x31.
REQ-009 mem_ren  output  1  memory read strobe, one cycle per word.
REQ-010 mem_addr  output  32  word-aligned byte address, valid while mem_ren=1.
REQ-011 mem_rdata  input  32  read data, valid exactly one cycle after mem_ren=1.
REQ-012 halt  output  1  core-freeze request, high from trigger until reset.
REQ-013 dump_valid  output  1  dump word available.
REQ-014 dump_ready  input  1  consumer accepts word.
REQ-015 dump_addr  output  32  byte address of current dump word.
REQ-016 dump_data  output  32  memory contents at dump_addr.
REQ-017 done  output  1  all DUMP_WORDS words transferred.

Function
REQ-018 FSM states: IDLE, READ, WAIT, SEND, DONE; 30-bit word index idx.
REQ-019 IDLE: if x30_i==HALT_SIG and x31_i==HALT_SIG in the same cycle -> READ, idx=0, halt=1 from next cycle; a match on only one register SHALL NOT trigger.
REQ-020 READ: mem_ren=1, mem_addr=DUMP_BASE+4*idx (mod 2^32, wrap permitted) -> WAIT unconditionally.
REQ-021 WAIT: register mem_rdata into dump_data and the READ address into dump_addr -> SEND.
REQ-022 SEND: dump_valid=1; dump_addr/dump_data SHALL hold stable while dump_valid=1 and dump_ready=0.
REQ-023 SEND with dump_ready=1: if idx==DUMP_WORDS-1 -> DONE, else idx+1 -> READ.
REQ-024 DONE: done=1, halt=1, dump_valid=0, mem_ren=0; remain until reset.
REQ-025 Minimum cost 3 cycles per word (READ, WAIT, SEND accepted same cycle); trigger-to-first-dump_valid latency = 3 cycles.
REQ-026 After trigger, x30_i/x31_i changes SHALL be ignored; exactly one dump per reset.
REQ-027 mem_ren SHALL be asserted only in READ; never two consecutive cycles.
REQ-028 dump_ready while dump_valid=0 SHALL have no effect.

Reset
REQ-029 When nrst=0 at a rising clk edge: state=IDLE, idx=0, halt=0, done=0, mem_ren=0, mem_addr=0, dump_valid=0, dump_addr=0, dump_data=0.
REQ-030 Reset asserted mid-dump SHALL abandon the transfer; no further mem_ren until a new trigger after reset release.
REQ-031 Signature present during reset SHALL NOT trigger; it triggers on the first cycle with nrst=1 if still present.

Verification
REQ-032 DUMP_WORDS=4, memory word i = 32'h1000+i, dump_ready=1, set x30=x31=BEEFBEEF -> 4 beats addr 0,4,8,C data 1000..1003, each 3 cycles apart, done=1 after last.
REQ-033 x30=BEEFBEEF, x31=0 for 20 cycles -> halt=0, mem_ren=0 throughout; then x31=BEEFBEEF -> halt=1 next cycle.
REQ-034 dump_ready=0 for 5 cycles in first SEND -> dump_valid held, dump_data/dump_addr unchanged, no mem_ren; ready=1 -> one beat accepted, next READ follows.
REQ-035 DUMP_BASE=32'hFFFF_FFF8, DUMP_WORDS=4 -> dump_addr FFFFFFF8, FFFFFFFC, 00000000, 00000004.
REQ-036 nrst=0 after 2nd beat accepted -> all outputs 0 next edge; signature held after release -> full dump restarts at DUMP_BASE.
REQ-037 DUMP_WORDS=1 -> exactly one beat, done=1 the cycle after acceptance, signature clear afterwards -> done/halt stay 1.
